// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM states, FIFO entry layout, bit-timing helper.
package uart_pkg;

  localparam int MAX_PAYLOAD = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef struct packed {
    logic [MAX_PAYLOAD-1:0] data;
    logic                   frame_err;
    logic                   parity_err;
    logic                   brk;
  } rx_entry_t;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, registered head; push into full FIFO without a pop is dropped and flagged.
// A pop makes the next entry visible on the following cycle; push+pop while full is accepted.
module uart_rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= i_push & ~w_do_push;
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overrun  = r_overrun;

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: 2-FF sync, 3-sample majority per bit, flags per frame, valid/ready FIFO output.
// Entry pushed at the mid-stop vote; optional parity bit with `define UART_RX_PARITY_EN.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
`ifdef UART_RX_PARITY_EN
  input  logic                          parity_en,
  input  logic                          parity_odd,
`endif
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_break,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID    = CW'(MID);
  localparam logic [CW-1:0] C_MID_P1 = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST   = CW'(CPB - 1);
  localparam logic [3:0]    C_LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]    C_LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_t               r_state;
  rx_state_t               w_next_state;
  logic [1:0]              r_sync;
  logic [CW-1:0]           r_cnt;
  logic [3:0]              r_bit_idx;
  logic [1:0]              r_samp;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_all_zero;
  logic                    r_frame_err;
  logic                    r_break;
`ifdef UART_RX_PARITY_EN
  logic                    r_par_acc;
  logic                    r_parity_err;
`endif
  logic                    w_rxd;
  logic                    w_vote;
  logic                    w_vote_now;
  logic                    w_bit_end;
  logic                    w_push;
  rx_entry_t               w_push_entry;
  rx_entry_t               w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_unused_head;

  assign w_rxd      = r_sync[1];
  assign w_vote_now = (r_cnt == C_MID_P1);
  assign w_bit_end  = (r_cnt == C_LAST);
  // samples at mid-1 and mid are held; the mid+1 sample is the live line
  assign w_vote     = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd) | (r_samp[1] & w_rxd);

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_push_entry.data[PAYLOAD_BITS-1:0] = r_shift;
    w_push_entry.frame_err = r_frame_err | ~w_vote;
    w_push_entry.brk       = (r_bit_idx == 4'd0) ? (r_all_zero & ~w_vote) : r_break;
`ifdef UART_RX_PARITY_EN
    w_push_entry.parity_err = r_parity_err;
`else
    w_push_entry.parity_err = 1'b0;
`endif
    if (!uart_rx_en) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (!w_rxd) w_next_state = START;
        START: begin
          if (w_vote_now && w_vote) w_next_state = IDLE;
          else if (w_bit_end)       w_next_state = DATA;
        end
        DATA: begin
          if (w_bit_end && r_bit_idx == C_LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
            w_next_state = parity_en ? PARITY : STOP;
`else
            w_next_state = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_bit_end) w_next_state = STOP;
`endif
        STOP: begin
          if (w_vote_now && r_bit_idx == C_LAST_STOP) begin
            w_next_state = IDLE;
            w_push       = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sync      <= 2'b11;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_samp      <= 2'b11;
      r_shift     <= '0;
      r_all_zero  <= 1'b1;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_acc    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (uart_rx_en) r_sync <= {r_sync[0], uart_rxd};

      // the detection cycle counts as cycle 0 of the start bit
      if (w_next_state == IDLE)  r_cnt <= '0;
      else if (r_state == IDLE)  r_cnt <= C_ONE;
      else if (w_bit_end)        r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;

      if (r_cnt == C_MID_M1) r_samp[0] <= w_rxd;
      if (r_cnt == C_MID)    r_samp[1] <= w_rxd;

      if (r_state == IDLE) begin
        r_bit_idx   <= '0;
        r_all_zero  <= 1'b1;
        r_frame_err <= 1'b0;
        r_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_par_acc    <= 1'b0;
        r_parity_err <= 1'b0;
`endif
      end else begin
        if (w_bit_end && w_next_state != r_state) r_bit_idx <= '0;
        else if (w_bit_end)                       r_bit_idx <= r_bit_idx + 1'b1;

        if (w_vote_now) begin
          case (r_state)
            DATA: begin
              r_shift    <= {w_vote, r_shift[PAYLOAD_BITS-1:1]};
              r_all_zero <= r_all_zero & ~w_vote;
`ifdef UART_RX_PARITY_EN
              r_par_acc  <= r_par_acc ^ w_vote;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
              r_parity_err <= r_par_acc ^ w_vote ^ parity_odd;
              r_all_zero   <= r_all_zero & ~w_vote;
            end
`endif
            STOP: begin
              r_frame_err <= w_push_entry.frame_err;
              r_break     <= w_push_entry.brk;
            end
            default: ;
          endcase
        end
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_entry),
    .i_pop      (rx_valid & rx_ready),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (fifo_count),
    .o_overrun  (rx_overrun)
  );

  assign rx_valid      = ~w_empty;
  assign rx_data       = w_head.data[PAYLOAD_BITS-1:0];
  assign rx_frame_err  = w_head.frame_err;
  assign rx_parity_err = w_head.parity_err;
  assign rx_break      = w_head.brk;
  assign w_unused_head = ^w_head.data | w_full;

endmodule
